// File: rtl/cache_line_evict.sv
// Cache line writeback engine: reads one line through the shared bank read port and writes it to memory as a BANK_NUM-beat burst.
// Optional CACHE_EVICT_DIRTY_STRB_EN: drive per-beat write strobes from the latched byte dirty mask instead of all-ones.
module cache_line_evict #(
  parameter int INDEX_AW = 8,
  parameter int TAG_W    = 20,
  parameter int DATA_W   = 32,
  parameter int BANK_NUM = 4,
  parameter int ADDR_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [INDEX_AW-1:0]          req_index_i,
  input  logic [TAG_W-1:0]             req_tag_i,
  input  logic [BANK_NUM*4-1:0]        req_dirty_i,
  output logic                         bank_rd_req_o,
  input  logic                         bank_rd_gnt_i,
  output logic [INDEX_AW-1:0]          bank_index_o,
  input  logic [BANK_NUM*DATA_W-1:0]   bank_rd_data_i,
  output logic                         mem_aw_valid_o,
  input  logic                         mem_aw_ready_i,
  output logic [ADDR_W-1:0]            mem_aw_addr_o,
  output logic                         mem_w_valid_o,
  input  logic                         mem_w_ready_i,
  output logic [DATA_W-1:0]            mem_w_data_o,
  output logic [3:0]                   mem_w_strb_o,
  output logic                         mem_w_last_o,
  input  logic                         mem_b_valid_i,
  output logic                         mem_b_ready_o,
  output logic                         busy_o,
  output logic                         done_o
);
  localparam int BEAT_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BANK_NUM - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_AW, S_W, S_B} state_t;

  state_t                            r_state;
  state_t                            w_next;
  logic [INDEX_AW-1:0]               r_index;
  logic [TAG_W-1:0]                  r_tag;
  logic [BANK_NUM-1:0][DATA_W-1:0]   r_line;
  logic [BEAT_W-1:0]                 r_beat;
  logic                              r_done;
  logic                              w_last;

`ifdef CACHE_EVICT_DIRTY_STRB_EN
  logic [BANK_NUM*4-1:0]             r_dirty;
`else
  logic                              w_unused_dirty;
  assign w_unused_dirty = ^req_dirty_i;
`endif

  assign w_last = (r_beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i)             w_next = S_RD;
      S_RD:   if (bank_rd_gnt_i)           w_next = S_CAP;
      S_CAP:                               w_next = S_AW;
      S_AW:   if (mem_aw_ready_i)          w_next = S_W;
      S_W:    if (mem_w_ready_i && w_last) w_next = S_B;
      S_B:    if (mem_b_valid_i)           w_next = S_IDLE;
      default:                             w_next = S_IDLE;
    endcase
  end

  // Datapath: latched request, line buffer, beat counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_index <= '0;
      r_tag   <= '0;
      r_line  <= '0;
      r_beat  <= '0;
      r_done  <= 1'b0;
`ifdef CACHE_EVICT_DIRTY_STRB_EN
      r_dirty <= '0;
`endif
    end else begin
      r_done <= (r_state == S_B) && mem_b_valid_i;
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_index <= req_index_i;
          r_tag   <= req_tag_i;
`ifdef CACHE_EVICT_DIRTY_STRB_EN
          r_dirty <= req_dirty_i;
`endif
        end
        S_CAP: r_line <= bank_rd_data_i;
        S_AW:  if (mem_aw_ready_i) r_beat <= '0;
        S_W:   if (mem_w_ready_i && !w_last) r_beat <= r_beat + BEAT_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs depend only on state and registers, never directly on inputs.
  always_comb begin
    req_ready_o    = (r_state == S_IDLE);
    busy_o         = (r_state != S_IDLE);
    bank_rd_req_o  = (r_state == S_RD);
    bank_index_o   = r_index;
    mem_aw_valid_o = 1'b0;
    mem_aw_addr_o  = '0;
    mem_w_valid_o  = 1'b0;
    mem_w_data_o   = '0;
    mem_w_strb_o   = 4'h0;
    mem_w_last_o   = 1'b0;
    mem_b_ready_o  = (r_state == S_B);
    done_o         = r_done;
    if (r_state == S_AW) begin
      mem_aw_valid_o = 1'b1;
      mem_aw_addr_o  = ADDR_W'({r_tag, r_index, 4'b0000});
    end
    if (r_state == S_W) begin
      mem_w_valid_o = 1'b1;
      mem_w_data_o  = r_line[r_beat];
      mem_w_last_o  = w_last;
`ifdef CACHE_EVICT_DIRTY_STRB_EN
      mem_w_strb_o  = r_dirty[{r_beat, 2'b00} +: 4];
`else
      mem_w_strb_o  = 4'hF;
`endif
    end
  end

endmodule

// File: tb/tb_cache_line_evict.sv
// Directed bench for cache_line_evict: burst timing, grant delay, W backpressure, back-to-back, reset mid-burst, strobes.
module tb_cache_line_evict;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, req_valid, req_ready;
  logic [7:0]   req_index, bank_index;
  logic [19:0]  req_tag;
  logic [15:0]  req_dirty;
  logic         bank_rd_req, bank_rd_gnt;
  logic [127:0] bank_data;
  logic         aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready, busy, done;
  logic [31:0]  aw_addr, w_data;
  logic [3:0]   w_strb;

  int n_tests = 0;
  int n_fail  = 0;

  cache_line_evict dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_index_i(req_index),
    .req_tag_i(req_tag), .req_dirty_i(req_dirty),
    .bank_rd_req_o(bank_rd_req), .bank_rd_gnt_i(bank_rd_gnt), .bank_index_o(bank_index),
    .bank_rd_data_i(bank_data),
    .mem_aw_valid_o(aw_valid), .mem_aw_ready_i(aw_ready), .mem_aw_addr_o(aw_addr),
    .mem_w_valid_o(w_valid), .mem_w_ready_i(w_ready), .mem_w_data_o(w_data),
    .mem_w_strb_o(w_strb), .mem_w_last_o(w_last),
    .mem_b_valid_i(b_valid), .mem_b_ready_o(b_ready),
    .busy_o(busy), .done_o(done)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] exp_strb(input logic [15:0] m, input int k);
    logic [3:0] s;
    s = m[k*4 +: 4];
`ifndef CACHE_EVICT_DIRTY_STRB_EN
    s = 4'hF;
`endif
    return s;
  endfunction

  // Presents a request for one cycle, returns in the first RD cycle with request inputs scrambled.
  task automatic issue(input logic [7:0] idx, input logic [19:0] tag, input logic [15:0] dirty);
    req_valid = 1'b1; req_index = idx; req_tag = tag; req_dirty = dirty;
    tick();
    req_valid = 1'b0; req_index = 8'hFF; req_tag = 20'hFFFFF; req_dirty = 16'h5A5A;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_index = 8'h12; req_tag = 20'h34567; req_dirty = 16'hFFFF;
    bank_rd_gnt = 1'b1; bank_data = '1; aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;
    tick(); tick();
    n_tests++;
    if ({req_ready, busy, bank_rd_req, aw_valid, w_valid, w_last, b_ready, done} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000000",
               {req_ready, busy, bank_rd_req, aw_valid, w_valid, w_last, b_ready, done});
    end
    n_tests++;
    if ({bank_index, aw_addr, w_data, w_strb} !== 76'h0) begin
      n_fail++;
      $display("FAIL reset_data: idx=%h addr=%h data=%h strb=%h want all 0", bank_index, aw_addr, w_data, w_strb);
    end
    rst = 1'b0; req_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] wd [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    bank_rd_gnt = 1'b1; aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;
    bank_data = {wd[3], wd[2], wd[1], wd[0]};
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready: got %b want 1", req_ready); end
    issue(8'h3C, 20'hABCDE, 16'h00F0);
    n_tests++;
    if (bank_rd_req !== 1'b1 || bank_index !== 8'h3C || busy !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rd: req=%b idx=%h busy=%b rdy=%b want 1 3c 1 0", bank_rd_req, bank_index, busy, req_ready);
    end
    tick();
    n_tests++;
    if (bank_rd_req !== 1'b0 || aw_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_cap: req=%b aw_valid=%b want 0 0", bank_rd_req, aw_valid);
    end
    tick();
    n_tests++;
    if (aw_valid !== 1'b1 || aw_addr !== 32'hABCDE3C0) begin
      n_fail++; $display("FAIL basic_aw: valid=%b addr=%h want 1 abcde3c0", aw_valid, aw_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (w_valid !== 1'b1 || w_data !== wd[k] || w_last !== (k == 3) || w_strb !== exp_strb(16'h00F0, k)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: v=%b data=%h last=%b strb=%h want 1 %h %b %h",
                 k, w_valid, w_data, w_last, w_strb, wd[k], (k == 3), exp_strb(16'h00F0, k));
      end
    end
    tick();
    n_tests++;
    if (b_ready !== 1'b1 || w_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_b: b_ready=%b w_valid=%b done=%b want 1 0 0", b_ready, w_valid, done);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: done=%b rdy=%b busy=%b want 1 1 0", done, req_ready, busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: done=%b want 0", done); end
  endtask

  task automatic test_grant_delay();
    logic [31:0] wd [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    bank_rd_gnt = 1'b0; aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;
    bank_data = {4{32'hDEADBEEF}};
    issue(8'h55, 20'h12345, 16'hFFFF);
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (bank_rd_req !== 1'b1 || bank_index !== 8'h55 || aw_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gnt_wait%0d: req=%b idx=%h aw_valid=%b want 1 55 0", c, bank_rd_req, bank_index, aw_valid);
      end
      tick();
    end
    bank_rd_gnt = 1'b1;
    tick();
    bank_rd_gnt = 1'b0;
    bank_data = {wd[3], wd[2], wd[1], wd[0]};
    n_tests++;
    if (aw_valid !== 1'b0 || bank_rd_req !== 1'b0) begin
      n_fail++; $display("FAIL gnt_cap: aw_valid=%b req=%b want 0 0", aw_valid, bank_rd_req);
    end
    tick();
    bank_data = {4{32'hDEADBEEF}};
    n_tests++;
    if (aw_valid !== 1'b1 || aw_addr !== 32'h12345550) begin
      n_fail++; $display("FAIL gnt_aw: valid=%b addr=%h want 1 12345550", aw_valid, aw_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (w_valid !== 1'b1 || w_data !== wd[k]) begin
        n_fail++; $display("FAIL gnt_beat%0d: v=%b data=%h want 1 %h", k, w_valid, w_data, wd[k]);
      end
    end
    tick(); tick();
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL gnt_done: done=%b want 1", done); end
    tick();
  endtask

  task automatic test_w_backpressure();
    logic [31:0] wd [4] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int beat = 0;
    int hs = 0;
    bank_rd_gnt = 1'b1; aw_ready = 1'b1; w_ready = 1'b0; b_valid = 1'b0;
    bank_data = {wd[3], wd[2], wd[1], wd[0]};
    issue(8'hA5, 20'h0F0F0, 16'h0F0F);
    tick(); tick(); tick();
    for (int i = 0; i < 7; i++) begin
      w_ready = pat[i];
      n_tests++;
      if (w_valid !== 1'b1 || w_data !== wd[beat] || w_last !== (beat == 3) || w_strb !== exp_strb(16'h0F0F, beat)) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: v=%b data=%h last=%b strb=%h want 1 %h %b %h",
                 i, w_valid, w_data, w_last, w_strb, wd[beat], (beat == 3), exp_strb(16'h0F0F, beat));
      end
      if (pat[i]) begin beat++; hs++; end
      tick();
    end
    w_ready = 1'b0;
    n_tests++;
    if (b_ready !== 1'b1 || w_valid !== 1'b0 || hs != 4) begin
      n_fail++; $display("FAIL bp_to_b: b_ready=%b w_valid=%b handshakes=%0d want 1 0 4", b_ready, w_valid, hs);
    end
    tick();
    n_tests++;
    if (b_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL bp_b_hold: b_ready=%b done=%b want 1 0", b_ready, done);
    end
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    n_tests++;
    if (done !== 1'b1 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_done: done=%b b_ready=%b want 1 0", done, b_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bank_rd_gnt = 1'b1; aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;
    bank_data = {32'h4, 32'h3, 32'h2, 32'h1};
    issue(8'h11, 20'h11111, 16'hFFFF);
    tick(); tick(); tick();
    req_valid = 1'b1; req_index = 8'h22; req_tag = 20'h22222;
    n_tests++;
    if (req_ready !== 1'b0 || w_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_busy: rdy=%b w_valid=%b want 0 1", req_ready, w_valid);
    end
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (bank_index !== 8'h11 || w_data !== 32'h2) begin
      n_fail++; $display("FAIL b2b_ignored: idx=%h data=%h want 11 00000002", bank_index, w_data);
    end
    tick(); tick(); tick(); tick();
    n_tests++;
    if (done !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done1: done=%b rdy=%b want 1 1", done, req_ready);
    end
    bank_data = {32'h8, 32'h7, 32'h6, 32'h5};
    issue(8'h22, 20'h22222, 16'hFFFF);
    n_tests++;
    if (bank_rd_req !== 1'b1 || bank_index !== 8'h22 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: req=%b idx=%h done=%b want 1 22 0", bank_rd_req, bank_index, done);
    end
    tick(); tick();
    n_tests++;
    if (aw_valid !== 1'b1 || aw_addr !== 32'h22222220) begin
      n_fail++; $display("FAIL b2b_aw: valid=%b addr=%h want 1 22222220", aw_valid, aw_addr);
    end
    tick();
    n_tests++;
    if (w_data !== 32'h5) begin n_fail++; $display("FAIL b2b_beat0: data=%h want 00000005", w_data); end
    tick(); tick(); tick(); tick(); tick();
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: done=%b want 1", done); end
    tick();
  endtask

  task automatic test_reset_mid();
    bank_rd_gnt = 1'b1; aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;
    bank_data = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444};
    issue(8'h77, 20'h77777, 16'hFFFF);
    tick(); tick(); tick(); tick(); tick();
    n_tests++;
    if (w_valid !== 1'b1 || w_data !== 32'h66666666) begin
      n_fail++; $display("FAIL rstmid_pre: v=%b data=%h want 1 66666666", w_valid, w_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({req_ready, busy, bank_rd_req, aw_valid, w_valid, w_last, b_ready, done} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: got %b want 10000000",
               {req_ready, busy, bank_rd_req, aw_valid, w_valid, w_last, b_ready, done});
    end
    n_tests++;
    if ({bank_index, aw_addr, w_data, w_strb} !== 76'h0) begin
      n_fail++;
      $display("FAIL rstmid_data: idx=%h addr=%h data=%h strb=%h want all 0", bank_index, aw_addr, w_data, w_strb);
    end
    bank_data = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
    issue(8'h3C, 20'h00001, 16'hFFFF);
    tick(); tick();
    n_tests++;
    if (aw_valid !== 1'b1 || aw_addr !== 32'h000013C0) begin
      n_fail++; $display("FAIL rstmid_aw: valid=%b addr=%h want 1 000013c0", aw_valid, aw_addr);
    end
    tick();
    n_tests++;
    if (w_data !== 32'h0A0A0A0A || w_last !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_beat0: data=%h last=%b want 0a0a0a0a 0", w_data, w_last);
    end
    tick(); tick(); tick();
    n_tests++;
    if (w_data !== 32'h0D0D0D0D || w_last !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_beat3: data=%h last=%b want 0d0d0d0d 1", w_data, w_last);
    end
    tick(); tick();
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL rstmid_done: done=%b want 1", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grant_delay();
    test_w_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
